// File: rtl/bp_cce_pkg.sv
// CCE directory types and sizing helpers.
package bp_cce_pkg;
    import bp_common_pkg::*;

    typedef enum logic [1:0] {
        e_DIR_SEQ_IDLE,
        e_DIR_SEQ_READ,
        e_DIR_SEQ_DRAIN,
        e_DIR_SEQ_DONE
    } bp_cce_dir_seq_state_e;

    function automatic int bp_safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    // Directory entry is {coh_state, tag}, tag in the low bits.
    function automatic int bp_cce_dir_entry_width(input int tag_width);
        return tag_width + coh_bits_gp;
    endfunction

endpackage

// File: rtl/bp_common_pkg.sv
// Types shared across BlackParrot blocks: coherence state encoding.
package bp_common_pkg;

    typedef enum logic [2:0] {
        e_COH_I = 3'd0,
        e_COH_S = 3'd1,
        e_COH_E = 3'd2,
        e_COH_F = 3'd3,
        e_COH_M = 3'd6,
        e_COH_O = 3'd7
    } bp_coh_states_e;

    localparam int coh_bits_gp = $bits(bp_coh_states_e);

endpackage

// File: rtl/bp_cce_dir_tag_checker.sv
// Matches one directory row against a tag; per tag set, reports the lowest
// valid (non-I) way whose tag matches. Entry e = set*assoc_p + way.
module bp_cce_dir_tag_checker
    import bp_common_pkg::*;
    import bp_cce_pkg::*;
#(
    parameter int assoc_p            = 2,
    parameter int tag_width_p        = 8,
    parameter int tag_sets_per_row_p = 2,
    localparam int lg_assoc_lp       = bp_safe_clog2(assoc_p),
    localparam int entry_width_lp    = bp_cce_dir_entry_width(tag_width_p),
    localparam int row_width_lp      = tag_sets_per_row_p*assoc_p*entry_width_lp
) (
    input  logic [row_width_lp-1:0]                            row_i,
    input  logic [tag_sets_per_row_p-1:0]                      row_v_i,
    input  logic [tag_width_p-1:0]                             tag_i,
    output logic [tag_sets_per_row_p-1:0]                      sharers_hits_o,
    output logic [tag_sets_per_row_p-1:0][lg_assoc_lp-1:0]     sharers_ways_o,
    output bp_coh_states_e [tag_sets_per_row_p-1:0]            sharers_coh_states_o
);

    always_comb begin
        sharers_hits_o = '0;
        sharers_ways_o = '0;
        for (int s = 0; s < tag_sets_per_row_p; s++) begin
            sharers_coh_states_o[s] = e_COH_I;
        end
        // Walk ways high to low so the lowest matching way wins.
        for (int s = 0; s < tag_sets_per_row_p; s++) begin
            for (int w = assoc_p-1; w >= 0; w--) begin
                if (row_v_i[s]
                    && row_i[(s*assoc_p+w)*entry_width_lp +: tag_width_p] == tag_i
                    && row_i[(s*assoc_p+w)*entry_width_lp+tag_width_p +: coh_bits_gp] != e_COH_I) begin
                    sharers_hits_o[s]       = 1'b1;
                    sharers_ways_o[s]       = lg_assoc_lp'(w);
                    sharers_coh_states_o[s] = bp_coh_states_e'(
                        row_i[(s*assoc_p+w)*entry_width_lp+tag_width_p +: coh_bits_gp]);
                end
            end
        end
    end

endmodule

// File: rtl/bp_cce_dir_read_sequencer.sv
// Scans every directory row of one way group, tag-checks each returned row
// and gathers per-LCE hit/way/state into a sharers vector on valid/yumi.
module bp_cce_dir_read_sequencer
    import bp_common_pkg::*;
    import bp_cce_pkg::*;
#(
    parameter int num_lce_p          = 4,
    parameter int num_way_groups_p   = 4,
    parameter int assoc_p            = 2,
    parameter int tag_width_p        = 8,
    parameter int tag_sets_per_row_p = 2,
    localparam int rows_per_wg_lp    = num_lce_p/tag_sets_per_row_p,
    localparam int lg_rows_lp        = bp_safe_clog2(rows_per_wg_lp),
    localparam int lg_assoc_lp       = bp_safe_clog2(assoc_p),
    localparam int wg_width_lp       = bp_safe_clog2(num_way_groups_p),
    localparam int entry_width_lp    = bp_cce_dir_entry_width(tag_width_p),
    localparam int row_width_lp      = tag_sets_per_row_p*assoc_p*entry_width_lp,
    localparam int addr_width_lp     = bp_safe_clog2(num_way_groups_p*rows_per_wg_lp)
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic                                   v_i,
    output logic                                   ready_o,
    input  logic [wg_width_lp-1:0]                 wg_id_i,
    input  logic [tag_width_p-1:0]                 tag_i,
    output logic                                   ram_r_v_o,
    output logic [addr_width_lp-1:0]               ram_addr_o,
    input  logic [row_width_lp-1:0]                ram_row_i,
    output logic                                   v_o,
    input  logic                                   yumi_i,
    output logic [num_lce_p-1:0]                   sharers_hits_o,
    output logic [num_lce_p-1:0][lg_assoc_lp-1:0]  sharers_ways_o,
    output bp_coh_states_e [num_lce_p-1:0]         sharers_coh_states_o,
    output logic                                   busy_o
);

    bp_cce_dir_seq_state_e state_q, state_d;

    logic [wg_width_lp-1:0]                  wg_q;
    logic [tag_width_p-1:0]                  tag_q;
    logic [lg_rows_lp-1:0]                   row_cnt_q;
    logic                                    rd_pending_q;
    logic [lg_rows_lp-1:0]                   cap_idx_q;
    logic [num_lce_p-1:0]                    hits_q;
    logic [num_lce_p-1:0][lg_assoc_lp-1:0]   ways_q;
    logic [num_lce_p-1:0][coh_bits_gp-1:0]   states_q;

    logic [tag_sets_per_row_p-1:0]                  chk_hits;
    logic [tag_sets_per_row_p-1:0][lg_assoc_lp-1:0] chk_ways;
    bp_coh_states_e [tag_sets_per_row_p-1:0]        chk_states;

    bp_cce_dir_tag_checker #(
        .assoc_p            (assoc_p),
        .tag_width_p        (tag_width_p),
        .tag_sets_per_row_p (tag_sets_per_row_p)
    ) u_tag_checker (
        .row_i                (ram_row_i),
        .row_v_i              ({tag_sets_per_row_p{rd_pending_q}}),
        .tag_i                (tag_q),
        .sharers_hits_o       (chk_hits),
        .sharers_ways_o       (chk_ways),
        .sharers_coh_states_o (chk_states)
    );

    always_comb begin
        state_d   = state_q;
        ready_o   = 1'b0;
        ram_r_v_o = 1'b0;
        v_o       = 1'b0;
        case (state_q)
            e_DIR_SEQ_IDLE: begin
                ready_o = 1'b1;
                if (v_i) state_d = e_DIR_SEQ_READ;
            end
            e_DIR_SEQ_READ: begin
                ram_r_v_o = 1'b1;
                if (row_cnt_q == lg_rows_lp'(rows_per_wg_lp-1)) state_d = e_DIR_SEQ_DRAIN;
            end
            e_DIR_SEQ_DRAIN: state_d = e_DIR_SEQ_DONE;
            e_DIR_SEQ_DONE: begin
                v_o = 1'b1;
                if (yumi_i) state_d = e_DIR_SEQ_IDLE;
            end
            default: state_d = e_DIR_SEQ_IDLE;
        endcase
    end

    // Row address wraps in addr_width_lp bits by construction.
    always_comb begin
        ram_addr_o = '0;
        if (ram_r_v_o) begin
            ram_addr_o = addr_width_lp'(wg_q) * addr_width_lp'(rows_per_wg_lp)
                       + addr_width_lp'(row_cnt_q);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= e_DIR_SEQ_IDLE;
            wg_q         <= '0;
            tag_q        <= '0;
            row_cnt_q    <= '0;
            rd_pending_q <= 1'b0;
            cap_idx_q    <= '0;
            hits_q       <= '0;
            ways_q       <= '0;
            states_q     <= '0;
        end else begin
            state_q      <= state_d;
            rd_pending_q <= (state_q == e_DIR_SEQ_READ);
            cap_idx_q    <= row_cnt_q;
            if (state_q == e_DIR_SEQ_IDLE && v_i) begin
                wg_q      <= wg_id_i;
                tag_q     <= tag_i;
                row_cnt_q <= '0;
                hits_q    <= '0;
                ways_q    <= '0;
                states_q  <= '0;
            end else if (state_q == e_DIR_SEQ_READ) begin
                row_cnt_q <= row_cnt_q + 1'b1;
            end
            // Scatter tag set s of row cap_idx into LCE 2*cap_idx+s.
            if (rd_pending_q && (state_q == e_DIR_SEQ_READ || state_q == e_DIR_SEQ_DRAIN)) begin
                for (int i = 0; i < rows_per_wg_lp; i++) begin
                    if (cap_idx_q == lg_rows_lp'(i)) begin
                        for (int s = 0; s < tag_sets_per_row_p; s++) begin
                            hits_q[tag_sets_per_row_p*i+s]   <= chk_hits[s];
                            ways_q[tag_sets_per_row_p*i+s]   <= chk_ways[s];
                            states_q[tag_sets_per_row_p*i+s] <= chk_states[s];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        for (int l = 0; l < num_lce_p; l++) begin
            sharers_coh_states_o[l] = bp_coh_states_e'(states_q[l]);
        end
    end

    assign sharers_hits_o = hits_q;
    assign sharers_ways_o = ways_q;
    assign busy_o         = (state_q != e_DIR_SEQ_IDLE);

endmodule
